johnson_phase_decoder: RTL and testbench

JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

---
 rtl/johnson_phase_decoder.sv | 142 ++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson counter into a one-hot phase once the sequence has been
// seen advancing cleanly. Illegal or out-of-order codes are flagged as sticky errors.
module johnson_phase_decoder #(
    parameter int LOCK_CNT = 3
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       EN,
    input  logic [3:0] jin,
    input  logic       clr_err,
    output logic [7:0] phase,
    output logic [2:0] phase_idx,
    output logic       locked,
    output logic       err_illegal,
    output logic       err_seq,
    output logic [7:0] cycle_cnt,
    output logic       wrap
);

    typedef enum logic [1:0] {UNLOCK, TRACK, LOCKED, FAULT} state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

    function automatic logic code_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b1000, 4'b1100, 4'b1110,
            4'b1111, 4'b0111, 4'b0011, 4'b0001: code_legal = 1'b1;
            default:                            code_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] code_idx(input logic [3:0] c);
        case (c)
            4'b1000: code_idx = 3'd1;
            4'b1100: code_idx = 3'd2;
            4'b1110: code_idx = 3'd3;
            4'b1111: code_idx = 3'd4;
            4'b0111: code_idx = 3'd5;
            4'b0011: code_idx = 3'd6;
            4'b0001: code_idx = 3'd7;
            default: code_idx = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] i);
        onehot = 8'b0000_0001 << i;
    endfunction

    state_t     state;
    logic [3:0] prev;
    logic       prev_vld;
    logic [3:0] run;

    logic       jin_legal;
    logic [2:0] jin_idx;
    logic [2:0] prev_idx;
    logic       is_hold;
    logic       is_succ;
    logic       cycle_done;

    assign jin_legal  = code_legal(jin);
    assign jin_idx    = code_idx(jin);
    assign prev_idx   = code_idx(prev);
    assign is_hold    = prev_vld && (jin == prev);
    assign is_succ    = prev_vld && jin_legal && code_legal(prev) &&
                        (jin_idx == 3'(prev_idx + 3'd1));
    // A completed Johnson cycle is the step from index 7 back to index 0.
    assign cycle_done = is_succ && (prev_idx == 3'd7);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state       <= UNLOCK;
            prev        <= 4'b0000;
            prev_vld    <= 1'b0;
            run         <= 4'd0;
            phase       <= 8'd0;
            phase_idx   <= 3'd0;
            locked      <= 1'b0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            cycle_cnt   <= 8'd0;
            wrap        <= 1'b0;
        end else if (!EN) begin
            wrap <= 1'b0;
        end else begin
            prev     <= jin;
            prev_vld <= 1'b1;
            wrap     <= 1'b0;
            case (state)
                UNLOCK: begin
                    if (jin_legal) begin
                        state <= TRACK;
                        run   <= 4'd0;
                    end
                end
                TRACK: begin
                    if (is_succ) begin
                        if (4'(run + 4'd1) == LOCK_RUN) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            phase     <= onehot(jin_idx);
                            phase_idx <= jin_idx;
                        end
                        run <= 4'(run + 4'd1);
                    end else if (!is_hold) begin
                        state <= UNLOCK;
                        run   <= 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_succ || is_hold) begin
                        phase     <= onehot(jin_idx);
                        phase_idx <= jin_idx;
                        if (cycle_done) begin
                            cycle_cnt <= 8'(cycle_cnt + 8'd1);
                            wrap      <= (cycle_cnt == 8'hFF);
                        end
                    end else begin
                        // A fresh fault here wins over any clr_err in the same cycle.
                        state     <= FAULT;
                        locked    <= 1'b0;
                        phase     <= 8'd0;
                        phase_idx <= 3'd0;
                        run       <= 4'd0;
                        if (!jin_legal) err_illegal <= 1'b1;
                        else            err_seq     <= 1'b1;
                    end
                end
                FAULT: begin
                    if (clr_err) begin
                        state       <= UNLOCK;
                        err_illegal <= 1'b0;
                        err_seq     <= 1'b0;
                        prev_vld    <= 1'b0;
                    end
                end
                default: state <= UNLOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: stimulus queues expected outputs, a
// monitor pops and compares them after every rising edge.
module tb_johnson_phase_decoder;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       EN;
    logic [3:0] jin;
    logic       clr_err;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       locked;
    logic       err_illegal;
    logic       err_seq;
    logic [7:0] cycle_cnt;
    logic       wrap;

    johnson_phase_decoder #(.LOCK_CNT(3)) dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .jin(jin), .clr_err(clr_err),
        .phase(phase), .phase_idx(phase_idx), .locked(locked),
        .err_illegal(err_illegal), .err_seq(err_seq),
        .cycle_cnt(cycle_cnt), .wrap(wrap)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [22:0] exp;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    logic [3:0] C [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                          4'b1111, 4'b0111, 4'b0011, 4'b0001};

    function automatic logic [22:0] outs_now();
        return {phase, phase_idx, locked, err_illegal, err_seq, cycle_cnt, wrap};
    endfunction

    function automatic logic [22:0] ex(input logic [7:0] ph, input logic [2:0] ix,
                                       input logic l, input logic ei, input logic es,
                                       input logic [7:0] c, input logic w);
        return {ph, ix, l, ei, es, c, w};
    endfunction

    function automatic logic [22:0] lk(input int ix, input int c, input logic w);
        logic [7:0] ph;
        ph = 8'b0000_0001 << ix;
        return ex(ph, 3'(ix), 1'b1, 1'b0, 1'b0, 8'(c), w);
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ph,ix,lk,ei,es,cnt,wr}=%h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per rising edge once stimulus starts.
    always @(posedge CLK) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.name, outs_now(), e.exp);
        end
    end

    task automatic step(input string name, input logic [3:0] j, input logic e,
                        input logic ce, input logic [22:0] exp);
        sb_t s;
        jin     = j;
        EN      = e;
        clr_err = ce;
        s.exp   = exp;
        s.name  = name;
        sb_q.push_back(s);
        @(posedge CLK);
        #2;
    endtask

    logic [22:0] z0;

    initial begin
        CLR = 1'b0; EN = 1'b0; jin = 4'b0000; clr_err = 1'b0;
        z0 = ex(8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        #12;
        check("reset_state", outs_now(), z0);
        CLR = 1'b1;

        // Acquire lock on 0000,1000,1100,1110
        step("lock_s0", C[0], 1, 0, z0);
        step("lock_s1", C[1], 1, 0, z0);
        step("lock_s2", C[2], 1, 0, z0);
        step("lock_s3", C[3], 1, 0, ex(8'b0000_1000, 3'd3, 1, 0, 0, 8'd0, 0));
        step("lock_s4", C[4], 1, 0, ex(8'b0001_0000, 3'd4, 1, 0, 0, 8'd0, 0));

        // Illegal code while locked at index 4
        step("illegal_fault", 4'b1010, 1, 0, ex(8'd0, 3'd0, 0, 1, 0, 8'd0, 0));
        step("illegal_sticky", 4'b1010, 1, 0, ex(8'd0, 3'd0, 0, 1, 0, 8'd0, 0));
        step("illegal_clr", C[0], 1, 1, z0);

        // Relock at index 2, then out-of-order code with simultaneous clr_err
        step("relock_a0", C[7], 1, 0, z0);
        step("relock_a1", C[0], 1, 0, z0);
        step("relock_a2", C[1], 1, 0, z0);
        step("relock_a3", C[2], 1, 0, ex(8'b0000_0100, 3'd2, 1, 0, 0, 8'd0, 0));
        step("seq_fault_clr", C[5], 1, 1, ex(8'd0, 3'd0, 0, 0, 1, 8'd0, 0));
        step("seq_sticky", C[5], 1, 0, ex(8'd0, 3'd0, 0, 0, 1, 8'd0, 0));
        step("seq_clr", C[0], 1, 1, z0);

        // Hold while locked, then freeze with EN=0 on an illegal code
        step("relock_b0", C[0], 1, 0, z0);
        step("relock_b1", C[1], 1, 0, z0);
        step("relock_b2", C[2], 1, 0, z0);
        step("relock_b3", C[3], 1, 0, ex(8'b0000_1000, 3'd3, 1, 0, 0, 8'd0, 0));
        for (int h = 0; h < 3; h++)
            step("hold", C[3], 1, 0, ex(8'b0000_1000, 3'd3, 1, 0, 0, 8'd0, 0));
        for (int h = 0; h < 2; h++)
            step("en_freeze", 4'b1010, 0, 0, ex(8'b0000_1000, 3'd3, 1, 0, 0, 8'd0, 0));
        step("after_freeze", C[4], 1, 0, ex(8'b0001_0000, 3'd4, 1, 0, 0, 8'd0, 0));

        // Count 256 full cycles; wrap pulses on the roll to zero
        step("cnt_5", C[5], 1, 0, lk(5, 0, 0));
        step("cnt_6", C[6], 1, 0, lk(6, 0, 0));
        step("cnt_7", C[7], 1, 0, lk(7, 0, 0));
        step("cnt_first", C[0], 1, 0, lk(0, 1, 0));
        for (int c = 2; c <= 256; c++) begin
            for (int k = 1; k < 8; k++)
                step("cnt_mid", C[k], 1, 0, lk(k, c - 1, 0));
            step("cnt_roll", C[0], 1, 0, lk(0, c % 256, c == 256));
        end
        step("wrap_end", C[1], 1, 0, lk(1, 0, 0));
        for (int c = 1; c <= 5; c++) begin
            for (int k = 2; k < 8; k++)
                step("cnt5_mid", C[k], 1, 0, lk(k, c - 1, 0));
            step("cnt5_roll", C[0], 1, 0, lk(0, c, 0));
            step("cnt5_one", C[1], 1, 0, lk(1, c, 0));
        end

        // Count survives FAULT and UNLOCK
        step("keep_fault", 4'b0101, 1, 0, ex(8'd0, 3'd0, 0, 1, 0, 8'd5, 0));
        step("keep_clr", C[0], 1, 1, ex(8'd0, 3'd0, 0, 0, 0, 8'd5, 0));
        step("keep_r0", C[0], 1, 0, ex(8'd0, 3'd0, 0, 0, 0, 8'd5, 0));
        step("keep_r1", C[1], 1, 0, ex(8'd0, 3'd0, 0, 0, 0, 8'd5, 0));
        step("keep_r2", C[2], 1, 0, ex(8'd0, 3'd0, 0, 0, 0, 8'd5, 0));
        step("keep_r3", C[3], 1, 0, lk(3, 5, 0));

        // Asynchronous reset between edges while locked
        #1 CLR = 1'b0;
        #1 check("async_reset", outs_now(), z0);
        #2 CLR = 1'b1;
        step("post_reset0", C[0], 1, 0, z0);
        step("post_reset1", C[1], 1, 0, z0);

        n_assert++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
